// File: rtl/ro_pair_compare_if.sv
// Handshake and result bus of the ring-oscillator pair comparator.
// master = requester (drives start/selects and, in characterisation
// builds, the external ring waveforms); slave = the comparator.
interface ro_pair_compare_if #(
   parameter int NUM_RO = 8,
   parameter int CW     = 16
);
   localparam int SW = $clog2(NUM_RO);

   logic              start;
   logic [SW-1:0]     sel_a;
   logic [SW-1:0]     sel_b;
   logic [NUM_RO-1:0] ro_ext;
   logic              busy;
   logic              done;
   logic              response;
   logic              tie;
   logic              sel_err;
   logic [CW-1:0]     count_a;
   logic [CW-1:0]     count_b;

   modport master (
      output start, sel_a, sel_b, ro_ext,
      input  busy, done, response, tie, sel_err, count_a, count_b
   );

   modport slave (
      input  start, sel_a, sel_b, ro_ext,
      output busy, done, response, tie, sel_err, count_a, count_b
   );
endinterface

// File: rtl/ro_pair_compare.sv
// Ring-oscillator pair comparator (PUF-style response bit).
// Two selected rings run for a fixed clk window, are stopped, left to go
// quiet, and then their edge counts are sampled and compared in clk domain.

// One ring plus its private saturating edge counter.
module ro_lane #(
   parameter int STAGES     = 15,
   parameter int CW         = 16,
   parameter int USE_EXT_RO = 0
) (
   input  logic          en,
   input  logic          clr_n,
   input  logic          ro_ext,
   output logic [CW-1:0] cnt
);
   logic ro_out;
   logic cnt_en;

   if (USE_EXT_RO != 0) begin : g_ext
      // An external waveform keeps toggling regardless of en, so the count
      // is qualified by en instead of gating the clock (no spurious edge
      // when en rises while the waveform is already high).
      assign ro_out = ro_ext;
      assign cnt_en = en;
   end else begin : g_ring
      // Stage 0 is the enable NAND; the remaining stages are plain
      // inverters. All nets carry keep attributes so the loop survives.
      (* keep = "true", dont_touch = "true" *) logic [STAGES-1:0] stg;
      assign stg[0] = ~(en & stg[STAGES-1]);
      for (genvar j = 1; j < STAGES; j++) begin : g_inv
         assign stg[j] = ~stg[j-1];
      end
      assign ro_out = stg[STAGES-1];
      // The ring itself stops when en is low, so no extra qualification.
      assign cnt_en = 1'b1;
   end

   // Edge counter in the ring's own domain; saturates instead of wrapping.
   always_ff @(posedge ro_out or negedge clr_n) begin
      if (!clr_n)                   cnt <= '0;
      else if (cnt_en && cnt != '1) cnt <= cnt + 1'b1;
   end
endmodule

module ro_pair_compare #(
   parameter int NUM_RO     = 8,
   parameter int STAGES     = 15,
   parameter int CW         = 16,
   parameter int WINDOW     = 1024,
   parameter int SETTLE     = 4,
   parameter int USE_EXT_RO = 0
) (
   input  logic clk,
   input  logic rst_n,
   ro_pair_compare_if.slave bus
);
   localparam int SW   = $clog2(NUM_RO);
   localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_CAPTURE, S_DONE
   } state_t;

   state_t                     state, state_n;
   logic [TW-1:0]              tmr;
   logic [SW-1:0]              sel_a_q, sel_b_q;
   logic [NUM_RO-1:0]          en_q;
   logic                       clr_q;
   logic                       cnt_rst_n;
   logic                       sel_ok;
   logic [NUM_RO-1:0]          sel_mask;
   logic [NUM_RO-1:0][CW-1:0]  cnt;
   logic [CW-1:0]              cnt_a, cnt_b;

   assign sel_ok   = (bus.sel_a != bus.sel_b) &&
                     (int'(bus.sel_a) < NUM_RO) && (int'(bus.sel_b) < NUM_RO);
   assign sel_mask = (NUM_RO'(1) << sel_a_q) | (NUM_RO'(1) << sel_b_q);

   // Counters clear on reset or the registered CLEAR strobe; both sources
   // are flop outputs so the async clear is glitch-free.
   assign cnt_rst_n = rst_n & ~clr_q;

   for (genvar gi = 0; gi < NUM_RO; gi++) begin : g_lane
      ro_lane #(
         .STAGES    (STAGES),
         .CW        (CW),
         .USE_EXT_RO(USE_EXT_RO)
      ) u_lane (
         .en    (en_q[gi]),
         .clr_n (cnt_rst_n),
         .ro_ext(bus.ro_ext[gi]),
         .cnt   (cnt[gi])
      );
   end

   // Counts are only read in CAPTURE, after SETTLE quiet cycles, so the
   // ring-domain bits are stable and need no synchroniser.
   assign cnt_a = cnt[sel_a_q];
   assign cnt_b = cnt[sel_b_q];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   // Next-state logic; RUN and SETTLE end when the down-timer hits zero.
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:    if (bus.start) state_n = sel_ok ? S_CLEAR : S_DONE;
         S_CLEAR:   state_n = S_RUN;
         S_RUN:     if (tmr == '0) state_n = S_SETTLE;
         S_SETTLE:  if (tmr == '0) state_n = S_CAPTURE;
         S_CAPTURE: state_n = S_DONE;
         S_DONE:    state_n = S_IDLE;
         default:   state_n = S_IDLE;
      endcase
   end

   // Phase timer: loaded on entry to RUN/SETTLE, counts down to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  tmr <= '0;
      else if (state_n == S_RUN && state != S_RUN) tmr <= TW'(WINDOW - 1);
      else if (state_n == S_SETTLE && state != S_SETTLE)
                                                   tmr <= TW'(SETTLE - 1);
      else if (tmr != '0)                          tmr <= tmr - 1'b1;
   end

   // Ring enables and counter clear come straight from flops, decoded
   // from the next state so they line up exactly with CLEAR and RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q  <= '0;
         clr_q <= 1'b0;
      end else begin
         en_q  <= (state_n == S_RUN) ? sel_mask : '0;
         clr_q <= (state_n == S_CLEAR);
      end
   end

   // Select latch and result registers; results hold until the next DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_a_q      <= '0;
         sel_b_q      <= '0;
         bus.sel_err  <= 1'b0;
         bus.response <= 1'b0;
         bus.tie      <= 1'b0;
         bus.count_a  <= '0;
         bus.count_b  <= '0;
      end else if (state == S_IDLE && bus.start) begin
         if (sel_ok) begin
            sel_a_q     <= bus.sel_a;
            sel_b_q     <= bus.sel_b;
            bus.sel_err <= 1'b0;
         end else begin
            bus.sel_err  <= 1'b1;
            bus.response <= 1'b0;
            bus.tie      <= 1'b0;
         end
      end else if (state == S_CAPTURE) begin
         bus.count_a  <= cnt_a;
         bus.count_b  <= cnt_b;
         bus.response <= (cnt_a > cnt_b);
         bus.tie      <= (cnt_a == cnt_b);
      end
   end

   assign bus.busy = (state != S_IDLE);
   assign bus.done = (state == S_DONE);
endmodule

// File: doc/ro_pair_compare.md
RO_PAIR_COMPARE -- requirements
Module: ro_pair_compare

Interface
REQ-001 Parameter NUM_RO, default 8, number of ring oscillators in the bank (2..64).
REQ-002 Parameter STAGES, default 15, inversions per ring; odd, >=3; stage 0 is the enable NAND, stages 1..STAGES-1 are inverters, every net kept through synthesis.
REQ-003 Parameter CW, default 16, width of each edge counter and of each reported count.
REQ-004 Parameter WINDOW, default 1024, clk cycles the selected pair oscillates per measurement (1..65535).
REQ-005 Parameter SETTLE, default 4, clk cycles after disable before counts are captured (>=2).
REQ-006 Parameter USE_EXT_RO, default 0; 1 replaces internal rings with ro_ext bits (simulation and characterisation).
REQ-007 clk  input  1  system clock, all control logic on rising edge.
REQ-008 rst_n  input  1  reset; asynchronous, active-low.
REQ-009 start  input  1  one-cycle request to begin a measurement.
REQ-010 sel_a  input  clog2(NUM_RO)  index of ring A, sampled on accepted start.
REQ-011 sel_b  input  clog2(NUM_RO)  index of ring B, sampled on accepted start.
REQ-012 ro_ext  input  NUM_RO  external ring outputs, used only when USE_EXT_RO=1.
REQ-013 busy  output  1  high from accepted start until done pulse inclusive.
REQ-014 done  output  1  one-cycle pulse, result outputs valid from this cycle.
REQ-015 response  output  1  1 when count_a > count_b, else 0.
REQ-016 tie  output  1  1 when count_a == count_b.
REQ-017 sel_err  output  1  1 when last start had sel_a==sel_b or either index >= NUM_RO.
REQ-018 count_a, count_b  output  CW each  captured edge counts of ring A and ring B.

Function
REQ-019 Each ring SHALL oscillate only while its enable is high; only rings sel_a and sel_b are enabled, only in RUN.
REQ-020 Each ring SHALL drive a CW-bit counter clocked by its own output rising edge, cleared asynchronously by the control clear signal or rst_n.
REQ-021 Counters SHALL saturate at 2^CW-1, never wrap.
REQ-022 FSM states SHALL be IDLE, CLEAR, RUN, SETTLE, CAPTURE, DONE; encoding free.
REQ-023 IDLE: start with valid selects -> CLEAR, latching sel_a/sel_b and clearing sel_err; start with invalid selects -> DONE with sel_err=1, response=0, tie=0, counts unchanged, no ring enabled.
REQ-024 CLEAR: exactly 1 cycle, clear asserted from a register (glitch-free), all rings disabled -> RUN.
REQ-025 RUN: exactly WINDOW cycles with both selected enables high, from a register -> SETTLE.
REQ-026 SETTLE: exactly SETTLE cycles, all enables low, counters frozen -> CAPTURE.
REQ-027 CAPTURE: 1 cycle, register count_a/count_b from selected counters, compute response and tie -> DONE.
REQ-028 DONE: done=1 for 1 cycle -> IDLE.
REQ-029 Latency start-to-done SHALL be 1+WINDOW+SETTLE+2 cycles for valid selects; 1 cycle for invalid.
REQ-030 start while busy SHALL be ignored; no queuing.
REQ-031 response, tie, sel_err, counts SHALL hold until the next DONE.
REQ-032 Counter-to-clk crossing SHALL be safe by construction: counters captured only after SETTLE quiet cycles; no synchroniser on count bits.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, disable all rings, clear all counters, and drive busy, done, response, tie, sel_err = 0, count_a = count_b = 0.
REQ-034 Reset during RUN or SETTLE SHALL abort the measurement with no done pulse; first start after release behaves as from power-up.

Verification
REQ-035 USE_EXT_RO=1, WINDOW=100, ro_ext[2] period 3 clk, ro_ext[5] period 4 clk, start sel_a=2 sel_b=5 -> done after 107 cycles, count_a=33±1, count_b=25±1, response=1, tie=0.
REQ-036 Same bench, sel_a=5 sel_b=2 -> response=0; identical periods on both rings -> tie=1, response=0 (±1 edge phase allowed, tie checked with phase-aligned stimulus).
REQ-037 sel_a=sel_b=3 -> done one cycle after start, sel_err=1, no ro enable observed high.
REQ-038 CW=4, ring A 40 edges in window -> count_a=15 (saturated), no wrap.
REQ-039 start pulsed every cycle during busy -> exactly one done per measurement; rst_n low mid-RUN -> busy=0 immediately, all outputs 0, no done.
REQ-040 USE_EXT_RO=0 synthesis check: NUM_RO*STAGES kept combinational stages, no optimised-away inverter.
